// File: rtl/jump_physics_if.sv
// Frame strobe, jump request inputs and sprite position/status outputs of jump_physics.
interface jump_physics_if #(
    parameter int unsigned Y_W = 10
);
    logic           frame_tick;
    logic           can_jump;
    logic           jump_btn;
    logic [Y_W-1:0] player_y;
    logic           airborne;
    logic           jump_start;
    logic           landed;
    logic [1:0]     state;

    modport master (
        output frame_tick, can_jump, jump_btn,
        input  player_y, airborne, jump_start, landed, state
    );

    modport slave (
        input  frame_tick, can_jump, jump_btn,
        output player_y, airborne, jump_start, landed, state
    );
endinterface

// File: rtl/jump_physics.sv
// Vertical jump/gravity stage for the player sprite; physics advances once per frame_tick.
// Optional JUMP_VARIABLE_HEIGHT_EN: early button release halves upward velocity (short hops).
module jump_physics #(
    parameter int          GROUND_Y = 400,
    parameter int          JUMP_VEL = 12,
    parameter int          GRAVITY  = 1,
    parameter int          MAX_FALL = 12,
    parameter int unsigned Y_W      = 10,
    parameter int unsigned V_W      = 8
) (
    input  logic          proc_clk,
    input  logic          reset,
    jump_physics_if.slave phys_if
);

    localparam int unsigned S_W = Y_W + 1;

    localparam logic        [Y_W-1:0] GROUND_POS = Y_W'(GROUND_Y);
    localparam logic signed [S_W-1:0] GROUND_S   = S_W'(GROUND_Y);
    localparam logic signed [V_W-1:0] JUMP_V     = V_W'(JUMP_VEL);
    localparam logic signed [V_W-1:0] GRAV_V     = V_W'(GRAVITY);
    localparam logic signed [V_W-1:0] FALL_MIN   = V_W'(-MAX_FALL);

    typedef enum logic [1:0] {
        GROUND  = 2'd0,
        ASCEND  = 2'd1,
        DESCEND = 2'd2,
        LAND    = 2'd3
    } state_e;

    logic                  sync1_q, sync2_q, btn_prev_q;
    logic                  btn_rise;
    logic                  pending_q, pending_d;
    state_e                state_q, state_d;
    logic        [Y_W-1:0] y_q, y_d;
    logic signed [V_W-1:0] vel_q, vel_d;
    logic signed [V_W-1:0] vel_eff, vel_dec, vel_next;
    logic signed [S_W-1:0] y_next;
    logic                  airborne_q, airborne_d;
    logic                  jump_start_q, jump_start_d;
    logic                  landed_q, landed_d;
    logic                  accept;

    // Button synchronizer and rising-edge detect
    always_ff @(posedge proc_clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            btn_prev_q <= 1'b0;
        end else begin
            sync1_q    <= phys_if.jump_btn;
            sync2_q    <= sync1_q;
            btn_prev_q <= sync2_q;
        end
    end

    assign btn_rise = sync2_q & ~btn_prev_q;

`ifdef JUMP_VARIABLE_HEIGHT_EN
    localparam logic signed [V_W-1:0] VEL_ONE = V_W'(1);

    // Released button while rising cuts the remaining climb
    always_comb begin
        vel_eff = vel_q;
        if ((state_q == ASCEND) && !sync2_q && (vel_q > VEL_ONE)) begin
            vel_eff = vel_q >>> 1;
        end
    end
`else
    assign vel_eff = vel_q;
`endif

    // One physics step: position in Y_W+1 signed space, velocity clamped at terminal speed
    assign y_next   = {1'b0, y_q} - {{(S_W - V_W){vel_eff[V_W-1]}}, vel_eff};
    assign vel_dec  = vel_eff - GRAV_V;
    assign vel_next = (vel_dec < FALL_MIN) ? FALL_MIN : vel_dec;

    assign accept = (state_q == GROUND) && pending_q && phys_if.can_jump;

    always_ff @(posedge proc_clk or posedge reset) begin
        if (reset) begin
            state_q      <= GROUND;
            pending_q    <= 1'b0;
            y_q          <= GROUND_POS;
            vel_q        <= '0;
            airborne_q   <= 1'b0;
            jump_start_q <= 1'b0;
            landed_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            y_q          <= y_d;
            vel_q        <= vel_d;
            airborne_q   <= airborne_d;
            jump_start_q <= jump_start_d;
            landed_q     <= landed_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        y_d          = y_q;
        vel_d        = vel_q;
        jump_start_d = 1'b0;
        landed_d     = 1'b0;

        // A press survives at most until the next frame boundary
        if (phys_if.frame_tick) begin
            pending_d = 1'b0;
        end
        if (btn_rise) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            GROUND: begin
                y_d   = GROUND_POS;
                vel_d = '0;
                if (accept) begin
                    vel_d        = JUMP_V;
                    state_d      = ASCEND;
                    jump_start_d = 1'b1;
                    pending_d    = 1'b0;
                end
            end
            ASCEND: begin
                if (phys_if.frame_tick) begin
                    if (y_next[S_W-1]) begin
                        y_d     = '0;
                        vel_d   = '0;
                        state_d = DESCEND;
                    end else begin
                        y_d   = y_next[Y_W-1:0];
                        vel_d = vel_next;
                        if (vel_next[V_W-1] || (vel_next == '0)) begin
                            state_d = DESCEND;
                        end
                    end
                end
            end
            DESCEND: begin
                if (phys_if.frame_tick) begin
                    if (y_next >= GROUND_S) begin
                        y_d      = GROUND_POS;
                        vel_d    = '0;
                        state_d  = LAND;
                        landed_d = 1'b1;
                    end else begin
                        y_d   = y_next[Y_W-1:0];
                        vel_d = vel_next;
                    end
                end
            end
            LAND: begin
                if (phys_if.frame_tick) begin
                    state_d = GROUND;
                end
            end
        endcase

        airborne_d = (state_d == ASCEND) || (state_d == DESCEND);
    end

    assign phys_if.player_y   = y_q;
    assign phys_if.airborne   = airborne_q;
    assign phys_if.jump_start = jump_start_q;
    assign phys_if.landed     = landed_q;
    assign phys_if.state      = state_q;

endmodule
